// File: rtl/stack_op_sequencer_if.sv
// Handshake and strobe bundle between the control unit and the stack-op sequencer.
// master: instruction decode side (drives requests); slave: the sequencer.
interface stack_op_sequencer_if #(
    parameter int unsigned STEP_COUNT = 4,
    parameter int unsigned R16_COUNT  = 6
);
    logic                  start;
    logic [2:0]            op;
    logic [1:0]            pair;
    logic                  cond_en;
    logic                  cond_met;
    logic                  stall;
    logic                  busy;
    logic                  done;
    logic [STEP_COUNT-1:0] step;
    logic [R16_COUNT-1:0]  read16;
    logic [R16_COUNT-1:0]  write16;
    logic [1:0]            increment16;
    logic                  address_out;
    logic                  mem_wr;
    logic                  mem_rd;
    logic [2:0]            byte_sel;
    logic                  pc_load;
    logic                  ir_fetch;
    logic                  ime_clear;

    modport master (
        output start, op, pair, cond_en, cond_met, stall,
        input  busy, done, step, read16, write16, increment16, address_out,
               mem_wr, mem_rd, byte_sel, pc_load, ir_fetch, ime_clear
    );

    modport slave (
        input  start, op, pair, cond_en, cond_met, stall,
        output busy, done, step, read16, write16, increment16, address_out,
               mem_wr, mem_rd, byte_sel, pc_load, ir_fetch, ime_clear
    );
endinterface

// File: rtl/stack_op_sequencer.sv
// Microcode sequencer for PUSH/POP/CALL/RET/RST (and optional interrupt dispatch).
// Each state lasts STEP_COUNT clocks; single-cycle strobes fire on the last step once
// any memory stall has cleared. Every op ends with an IR fetch M-cycle.
// Build option: define STACK_SEQ_INT_EN to enable interrupt dispatch on op 101.
module stack_op_sequencer #(
    parameter int unsigned STEP_COUNT = 4,
    parameter int unsigned R16_COUNT  = 6,
    parameter int unsigned SP_IDX     = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    stack_op_sequencer_if.slave bus
);
    localparam logic [2:0] OpPush = 3'b000;
    localparam logic [2:0] OpPop  = 3'b001;
    localparam logic [2:0] OpCall = 3'b010;
    localparam logic [2:0] OpRet  = 3'b011;
    localparam logic [2:0] OpRst  = 3'b100;
    localparam logic [2:0] OpInt  = 3'b101;

`ifdef STACK_SEQ_INT_EN
    localparam bit IntEn = 1'b1;
`else
    localparam bit IntEn = 1'b0;
`endif

    localparam logic [R16_COUNT-1:0]  SpSel     = (R16_COUNT)'(1) << SP_IDX;
    localparam logic [STEP_COUNT-1:0] StepFirst = (STEP_COUNT)'(1);

    typedef enum logic [3:0] {
        StIdle, StCond, StPrep, StWrHi, StWrLo, StRdLo, StRdHi, StJump, StFetch
    } state_e;

    state_e                state_q, state_d;
    logic [STEP_COUNT-1:0] step_q, step_d;
    logic [2:0]            op_q, op_d;
    logic [1:0]            pair_q, pair_d;
    logic                  last;
    logic                  fire;
    logic                  is_int;
    logic                  is_rp;
    logic [1:0]            byte_pair;

    // First state of an op, chosen from the request at start time.
    function automatic state_e entry_state(logic [2:0] op, logic cond_en);
        state_e s;
        s = StFetch;
        case (op)
            OpPush, OpRst: s = StPrep;
            OpPop:         s = StRdLo;
            OpCall:        s = cond_en ? StCond : StPrep;
            OpRet:         s = cond_en ? StCond : StRdLo;
            OpInt:         s = IntEn ? StCond : StFetch;
            default:       s = StFetch;
        endcase
        return s;
    endfunction

    assign last   = step_q[STEP_COUNT-1];
    assign fire   = last && !bus.stall;
    assign is_int = IntEn && (op_q == OpInt);
    assign is_rp  = (op_q == OpPush) || (op_q == OpPop);
    // PC bytes travel under pair code 10; register-pair ops use the latched pair.
    assign byte_pair = is_rp ? pair_q : 2'b10;

    // State, step counter and latched request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            step_q  <= '0;
            op_q    <= '0;
            pair_q  <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            op_q    <= op_d;
            pair_q  <= pair_d;
        end
    end

    // Next state: accept starts only in idle, advance on an unstalled last step.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        op_d    = op_q;
        pair_d  = pair_q;
        if (state_q == StIdle) begin
            if (bus.start) begin
                op_d    = bus.op;
                pair_d  = bus.pair;
                state_d = entry_state(bus.op, bus.cond_en);
                step_d  = StepFirst;
            end
        end else if (!bus.stall) begin
            if (last) begin
                case (state_q)
                    StCond: begin
                        if (is_int)             state_d = StPrep;
                        else if (!bus.cond_met) state_d = StFetch;
                        else if (op_q == OpRet) state_d = StRdLo;
                        else                    state_d = StPrep;
                    end
                    StPrep:  state_d = StWrHi;
                    StWrHi:  state_d = StWrLo;
                    StWrLo:  state_d = StFetch;
                    StRdLo:  state_d = StRdHi;
                    StRdHi:  state_d = (op_q == OpRet) ? StJump : StFetch;
                    StJump:  state_d = StFetch;
                    StFetch: state_d = StIdle;
                    default: state_d = StIdle;
                endcase
                step_d = (state_d == StIdle) ? '0 : StepFirst;
            end else begin
                step_d = step_q << 1;
            end
        end
    end

    // Per-state level outputs and last-step strobes.
    always_comb begin
        bus.busy        = (state_q != StIdle);
        bus.done        = 1'b0;
        bus.step        = step_q;
        bus.read16      = '0;
        bus.write16     = '0;
        bus.increment16 = 2'b00;
        bus.address_out = 1'b0;
        bus.mem_wr      = 1'b0;
        bus.mem_rd      = 1'b0;
        bus.byte_sel    = 3'b000;
        bus.pc_load     = 1'b0;
        bus.ir_fetch    = 1'b0;
        case (state_q)
            StPrep: begin
                bus.read16  = SpSel;
                bus.write16 = SpSel;
                if (fire) bus.increment16 = 2'b11;
            end
            StWrHi: begin
                bus.read16      = SpSel;
                bus.write16     = SpSel;
                bus.address_out = 1'b1;
                bus.byte_sel    = {byte_pair, 1'b1};
                if (fire) begin
                    bus.mem_wr      = 1'b1;
                    bus.increment16 = 2'b11;
                end
            end
            StWrLo: begin
                bus.read16      = SpSel;
                bus.address_out = 1'b1;
                bus.byte_sel    = {byte_pair, 1'b0};
                if (fire) begin
                    bus.mem_wr  = 1'b1;
                    bus.pc_load = (op_q != OpPush);
                end
            end
            StRdLo, StRdHi: begin
                bus.read16      = SpSel;
                bus.write16     = SpSel;
                bus.address_out = 1'b1;
                bus.byte_sel    = {byte_pair, state_q == StRdHi};
                if (fire) begin
                    bus.mem_rd      = 1'b1;
                    bus.increment16 = 2'b01;
                end
            end
            StJump: begin
                if (fire) bus.pc_load = 1'b1;
            end
            StFetch: begin
                bus.ir_fetch = 1'b1;
                bus.done     = fire;
            end
            default: ;
        endcase
    end

`ifdef STACK_SEQ_INT_EN
    assign bus.ime_clear = (state_q == StCond) && is_int && fire;
`else
    assign bus.ime_clear = 1'b0;
`endif
endmodule
